// File: rtl/matmul_accum_array.sv
// MAC_NUM signed MAC lanes sharing one broadcast weight per beat; dot products are
// accumulated over k_len beats, shifted, saturated and offered on a valid/ready port.
module matmul_accum_array #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned OUTPUT_WIDTH = 16,
  parameter int unsigned MAC_NUM      = 8,
  parameter int unsigned ACC_WIDTH    = 32,
  parameter int unsigned K_WIDTH      = 9,
  parameter int unsigned SHIFT_WIDTH  = 5
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic                             en_i,
  input  logic                             start_i,
  input  logic [K_WIDTH-1:0]               k_len_i,
  input  logic [SHIFT_WIDTH-1:0]           shift_i,
  output logic                             busy_o,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [DATA_WIDTH*MAC_NUM-1:0]    din_i,
  input  logic [WEIGHT_WIDTH-1:0]          win_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [OUTPUT_WIDTH*MAC_NUM-1:0]  matmul_o,
  output logic [MAC_NUM-1:0]               sat_o
);

  localparam int unsigned PROD_W = DATA_WIDTH + WEIGHT_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};
  localparam logic [OUTPUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic [OUTPUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  state_t                           r_state;
  logic signed [ACC_WIDTH-1:0]      r_acc [MAC_NUM];
  logic [K_WIDTH-1:0]               r_cnt;
  logic [K_WIDTH-1:0]               r_klen;
  logic [SHIFT_WIDTH-1:0]           r_shift;
  logic [OUTPUT_WIDTH*MAC_NUM-1:0]  r_matmul;
  logic [MAC_NUM-1:0]               r_sat;

  logic signed [ACC_WIDTH-1:0]      w_acc_nxt [MAC_NUM];
  logic [OUTPUT_WIDTH*MAC_NUM-1:0]  w_res;
  logic [MAC_NUM-1:0]               w_sat;
  logic                             w_last;

  // Per-lane MAC plus the shift/saturate path, evaluated on the next accumulator value
  // so the final beat's result can be registered directly into the output stage.
  for (genvar g = 0; g < MAC_NUM; g++) begin : g_lane
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [ACC_WIDTH-1:0] w_t;

    assign w_prod = PROD_W'($signed(din_i[g*DATA_WIDTH +: DATA_WIDTH]))
                  * PROD_W'($signed(win_i));
    assign w_acc_nxt[g] = r_acc[g] + ACC_WIDTH'(w_prod);
    assign w_t = w_acc_nxt[g] >>> r_shift;

    assign w_res[g*OUTPUT_WIDTH +: OUTPUT_WIDTH] =
      (w_t > SAT_MAX) ? OUT_MAX :
      (w_t < SAT_MIN) ? OUT_MIN : w_t[OUTPUT_WIDTH-1:0];
    assign w_sat[g] = (w_t > SAT_MAX) || (w_t < SAT_MIN);
  end

  assign w_last = (r_cnt == r_klen - K_WIDTH'(1));

  // Control FSM, accumulators and output registers; en_i low freezes everything.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_klen   <= '0;
      r_shift  <= '0;
      r_matmul <= '0;
      r_sat    <= '0;
      for (int i = 0; i < MAC_NUM; i++) r_acc[i] <= '0;
    end else if (en_i) begin
      case (r_state)
        S_IDLE: begin
          if (start_i && (k_len_i != '0)) begin
            r_klen  <= k_len_i;
            r_shift <= shift_i;
            r_cnt   <= '0;
            for (int i = 0; i < MAC_NUM; i++) r_acc[i] <= '0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (valid_i) begin
            for (int i = 0; i < MAC_NUM; i++) r_acc[i] <= w_acc_nxt[i];
            r_cnt <= r_cnt + K_WIDTH'(1);
            if (w_last) begin
              r_matmul <= w_res;
              r_sat    <= w_sat;
              r_state  <= S_OUTPUT;
            end
          end
        end
        S_OUTPUT: begin
          if (ready_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = (r_state != S_IDLE);
  assign ready_o  = (r_state == S_ACCUM) && en_i;
  assign valid_o  = (r_state == S_OUTPUT) && en_i;
  assign matmul_o = r_matmul;
  assign sat_o    = r_sat;

endmodule
